// File: rtl/mul_div_unit_pkg.sv
// Shared types and helpers for the execute-stage multiply/divide unit.
package mul_div_unit_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned MD_ITER = 32;
   localparam int unsigned CNT_W   = 5;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } md_state_t;

   function automatic logic op_is_signed(md_op_t op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

   function automatic logic op_is_mul(md_op_t op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

   function automatic logic op_is_div(md_op_t op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // Magnitude of x, treating it as two's complement only for signed ops.
   function automatic logic [XLEN-1:0] magnitude(logic [XLEN-1:0] x, logic sgn);
      return (sgn && x[XLEN-1]) ? XLEN'(-x) : x;
   endfunction

endpackage

// File: rtl/mul_div_unit_div_core.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, 32 cycles.
module mul_div_unit_div_core
   import mul_div_unit_pkg::*;
(
   input  logic            clk,
   input  logic            resetn,
   input  logic            start_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] quotient_o,
   output logic [XLEN-1:0] remainder_o,
   output logic            last_step_o
);

   logic [XLEN-1:0]  rem_q, rem_d, quo_q, quo_d, div_q, div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             run_q, run_d, last_q, last_d;
   logic [XLEN:0]    rem_sh;
   logic [XLEN-1:0]  diff;

   assign rem_sh = {rem_q, quo_q[XLEN-1]};
   // Low bits suffice: the difference is only used when it is below the divisor.
   assign diff   = rem_sh[XLEN-1:0] - div_q;

   always_comb begin
      rem_d  = rem_q;
      quo_d  = quo_q;
      div_d  = div_q;
      cnt_d  = cnt_q;
      run_d  = run_q;
      last_d = 1'b0;
      if (flush_i) begin
         run_d = 1'b0;
      end else if (start_i) begin
         rem_d = '0;
         quo_d = a_i;
         div_d = b_i;
         cnt_d = CNT_W'(MD_ITER - 1);
         run_d = 1'b1;
      end else if (run_q) begin
         if (rem_sh >= {1'b0, div_q}) begin
            rem_d = diff;
            quo_d = {quo_q[XLEN-2:0], 1'b1};
         end else begin
            rem_d = rem_sh[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
         end
         cnt_d  = cnt_q - CNT_W'(1);
         run_d  = (cnt_q != '0);
         last_d = (cnt_q == CNT_W'(1));
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rem_q  <= '0;
         quo_q  <= '0;
         div_q  <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         last_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         div_q  <= div_d;
         cnt_q  <= cnt_d;
         run_q  <= run_d;
         last_q <= last_d;
      end
   end

   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;
   assign last_step_o = last_q;

endmodule

// File: rtl/mul_div_unit.sv
// MIPS multiply/divide unit: owns HI/LO, runs MULT/DIV iteratively, handles MTHI/MTLO.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int unsigned FAST_MUL = 1,
   parameter int unsigned WIDTH    = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             req_valid,
   output logic             req_ready,
   input  md_op_t           req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   md_state_t         state_q, state_d;
   md_op_t            op_q, op_d;
   logic [XLEN-1:0]   a_q, a_d, am_q, am_d, bm_q, bm_d;
   logic              neg_q, neg_d, rneg_q, rneg_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic              done_q, done_d, ready_q, ready_d, busy_q, busy_d;

   logic              accept, sgn, div_start, div_last;
   logic [XLEN-1:0]   div_quo, div_rem, quo_res, rem_res;
   logic [2*XLEN-1:0] prod_full, mul_res;
   logic [XLEN:0]     step_sum;

   assign accept    = req_valid && ready_q && !flush;
   assign sgn       = op_is_signed(req_op);
   assign prod_full = (2*XLEN)'(am_q) * (2*XLEN)'(bm_q);
   // Shift-add step: conditionally add multiplicand to the upper half, then shift right.
   assign step_sum  = (XLEN+1)'(acc_q[2*XLEN-1:XLEN]) + (acc_q[0] ? (XLEN+1)'(am_q) : '0);
   assign mul_res   = neg_q  ? -acc_q   : acc_q;
   assign quo_res   = neg_q  ? -div_quo : div_quo;
   assign rem_res   = rneg_q ? -div_rem : div_rem;

   mul_div_unit_div_core u_div (
      .clk         (clk),
      .resetn      (resetn),
      .start_i     (div_start),
      .flush_i     (flush),
      .a_i         (am_d),
      .b_i         (bm_d),
      .quotient_o  (div_quo),
      .remainder_o (div_rem),
      .last_step_o (div_last)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      am_d      = am_q;
      bm_d      = bm_q;
      neg_d     = neg_q;
      rneg_d    = rneg_q;
      acc_d     = acc_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      div_start = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (req_op == MD_MTHI) begin
                  hi_d = req_a;
               end else if (req_op == MD_MTLO) begin
                  lo_d = req_a;
               end else if (op_is_mul(req_op) || op_is_div(req_op)) begin
                  state_d   = ST_CALC;
                  op_d      = req_op;
                  a_d       = req_a;
                  am_d      = magnitude(req_a, sgn);
                  bm_d      = magnitude(req_b, sgn);
                  neg_d     = sgn && (req_a[XLEN-1] ^ req_b[XLEN-1]);
                  rneg_d    = sgn && req_a[XLEN-1];
                  acc_d     = {{XLEN{1'b0}}, bm_d};
                  // The divider also serves as the step timer for the slow multiplier.
                  div_start = op_is_div(req_op) || (FAST_MUL == 0);
               end
            end
         end
         ST_CALC: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               if (op_is_mul(op_q)) begin
                  acc_d = (FAST_MUL != 0) ? prod_full : {step_sum, acc_q[XLEN-1:1]};
               end
               if ((op_is_mul(op_q) && (FAST_MUL != 0)) || div_last) begin
                  state_d = ST_FIX;
               end
            end
         end
         ST_FIX: begin
            state_d = ST_IDLE;
            if (!flush) begin
               done_d = 1'b1;
               if (op_is_mul(op_q)) begin
                  {hi_d, lo_d} = mul_res;
               end else if (bm_q == '0) begin
                  lo_d = '1;
                  hi_d = a_q;
               end else begin
                  lo_d = quo_res;
                  hi_d = rem_res;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_IDLE);
      busy_d  = !ready_d;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         op_q    <= MD_MULT;
         a_q     <= '0;
         am_q    <= '0;
         bm_q    <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         am_q    <= am_d;
         bm_q    <= bm_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   assign req_ready = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: a fast-multiply and a slow-multiply instance share stimulus.
module tb_mul_div_unit;
   import mul_div_unit_pkg::*;

   logic        clk, resetn, req_valid, flush;
   md_op_t      req_op;
   logic [31:0] req_a, req_b;
   logic        f_ready, f_busy, f_done, s_ready, s_busy, s_done;
   logic [31:0] f_hi, f_lo, s_hi, s_lo;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          acc;
      int          lat;
   } exp_t;

   typedef struct packed {
      md_op_t      op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   exp_t q_f[$];
   exp_t q_s[$];
   exp_t ef, es;
   vec_t vecs[$];

   mul_div_unit #(.FAST_MUL(1), .WIDTH(32)) u_fast (
      .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(f_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
      .busy(f_busy), .done(f_done), .hi(f_hi), .lo(f_lo)
   );

   mul_div_unit #(.FAST_MUL(0), .WIDTH(32)) u_slow (
      .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(s_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
      .busy(s_busy), .done(s_done), .hi(s_hi), .lo(s_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitors: pop an expectation whenever a DUT pulses done.
   always @(negedge clk) begin
      if (resetn && f_done) begin
         if (q_f.size() == 0) begin
            chk("fast_spurious_done", 64'(f_done), 64'd0);
         end else begin
            ef = q_f.pop_front();
            chk("fast_hilo", {f_hi, f_lo}, {ef.hi, ef.lo});
            chk("fast_latency", 64'(cyc - ef.acc), 64'(ef.lat));
         end
      end
      if (resetn && s_done) begin
         if (q_s.size() == 0) begin
            chk("slow_spurious_done", 64'(s_done), 64'd0);
         end else begin
            es = q_s.pop_front();
            chk("slow_hilo", {s_hi, s_lo}, {es.hi, es.lo});
            chk("slow_latency", 64'(cyc - es.acc), 64'(es.lat));
         end
      end
   end

   task automatic issue(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input bit exp_done);
      exp_t e;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      if (exp_done) begin
         e.hi  = ehi;
         e.lo  = elo;
         e.acc = cyc;
         e.lat = ((op == MD_MULT) || (op == MD_MULTU)) ? 3 : 34;
         q_f.push_back(e);
         e.lat = 34;
         q_s.push_back(e);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_a     = $urandom;
      req_b     = $urandom;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!(f_ready && s_ready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", 64'(f_ready && s_ready), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs.push_back('{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
      vecs.push_back('{MD_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF});
      vecs.push_back('{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
      vecs.push_back('{MD_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
      vecs.push_back('{MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE});
      vecs.push_back('{MD_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF});
      vecs.push_back('{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
      vecs.push_back('{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
      vecs.push_back('{MD_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF});
      vecs.push_back('{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
      vecs.push_back('{MD_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1});

      resetn    = 1'b0;
      req_valid = 1'b0;
      flush     = 1'b0;
      req_op    = MD_MULT;
      req_a     = '0;
      req_b     = '0;
      repeat (3) @(negedge clk);
      chk("reset_hilo", {f_hi, f_lo}, 64'd0);
      chk("reset_ready_busy_done", {61'd0, f_ready, f_busy, f_done}, 64'd4);
      chk("reset_slow_ready_busy_done", {61'd0, s_ready, s_busy, s_done}, 64'd4);
      resetn = 1'b1;

      // MTHI then MTLO back-to-back: direct writes, no done, unit stays ready.
      issue(MD_MTHI, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 1'b0);
      chk("mthi_hi", 64'(f_hi), 64'h1234_5678);
      chk("mthi_ready", 64'(f_ready), 64'd1);
      issue(MD_MTLO, 32'h9ABC_DEF0, 32'h0, 32'h0, 32'h0, 1'b0);
      chk("mtlo_hilo", {f_hi, f_lo}, 64'h1234_5678_9ABC_DEF0);
      chk("mtlo_slow_hilo", {s_hi, s_lo}, 64'h1234_5678_9ABC_DEF0);
      chk("mtlo_ready", 64'(f_ready && s_ready), 64'd1);

      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b1);
         chk("busy_after_accept", 64'(f_busy && s_busy), 64'd1);
         wait_idle();
         if (!s_ready || q_s.size() != 0) wait_idle();
      end

      // Flush in the middle of a divide leaves HI/LO untouched and raises no done.
      issue(MD_MTHI, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0);
      issue(MD_MTLO, 32'd6, 32'd0, 32'd0, 32'd0, 1'b0);
      issue(MD_DIVU, 32'd77, 32'd3, 32'd0, 32'd0, 1'b0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_ready", 64'(f_ready && s_ready), 64'd1);
      chk("flush_hilo", {f_hi, f_lo}, 64'h0000_0005_0000_0006);
      repeat (40) @(negedge clk);
      chk("flush_hilo_later", {s_hi, s_lo}, 64'h0000_0005_0000_0006);
      issue(MD_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, 1'b1);
      wait_idle();

      // Asynchronous reset in the middle of CALC.
      issue(MD_DIV, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
      repeat (5) @(posedge clk);
      #3;
      resetn = 1'b0;
      #1;
      chk("async_reset_hilo", {f_hi, f_lo}, 64'd0);
      chk("async_reset_ctrl", {61'd0, f_ready, f_busy, f_done}, 64'd4);
      chk("async_reset_slow_ctrl", {61'd0, s_ready, s_busy, s_done}, 64'd4);
      @(negedge clk);
      resetn = 1'b1;

      // flush with req_valid in IDLE: request dropped, MT write suppressed.
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = MD_MTHI;
      req_a     = 32'hDEAD_BEEF;
      flush     = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("flush_idle_hi", 64'(f_hi), 64'd0);
      chk("flush_idle_ready", 64'(f_ready && s_ready), 64'd1);
      req_op = MD_DIV;
      repeat (2) @(posedge clk);
      #1;
      chk("flush_idle_no_busy", 64'(f_busy || s_busy), 64'd0);
      req_valid = 1'b0;
      flush     = 1'b0;
      repeat (40) @(negedge clk);

      chk("sb_drain_fast", 64'(q_f.size()), 64'd0);
      chk("sb_drain_slow", 64'(q_s.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
